// File: rtl/packet_rr_arbiter.sv
// ============================================================================
// Module   : packet_rr_arbiter
// Purpose  : Per-output round-robin packet arbiter for a 5-port router, with
//            a length-sized watchdog that releases stalled packets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module packet_rr_arbiter #(
  parameter int LEN_W = 12,
  parameter int SLACK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Lreq,
  input  logic             Nreq,
  input  logic             Ereq,
  input  logic             Wreq,
  input  logic             Sreq,
  input  logic [2:0]       Lflit_id,
  input  logic [2:0]       Nflit_id,
  input  logic [2:0]       Eflit_id,
  input  logic [2:0]       Wflit_id,
  input  logic [2:0]       Sflit_id,
  input  logic [LEN_W-1:0] Llength,
  input  logic [LEN_W-1:0] Nlength,
  input  logic [LEN_W-1:0] Elength,
  input  logic [LEN_W-1:0] Wlength,
  input  logic [LEN_W-1:0] Slength,
  input  logic             out_ready,
  output logic [4:0]       grant,
  output logic [2:0]       xbar_sel,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [0:0] c_IDLE      = 1'b0;
  localparam logic [0:0] c_HOLD      = 1'b1;
  localparam logic [2:0] c_FLIT_HEAD = 3'b001;
  localparam logic [2:0] c_FLIT_TAIL = 3'b100;
  localparam logic [2:0] c_NO_SEL    = 3'd7;

  logic [4:0]       w_req;
  logic [2:0]       w_fid [5];
  logic [LEN_W-1:0] w_len [5];
  logic [4:0]       w_cand;

  logic [0:0]       r_state;
  logic [4:0]       r_grant;
  logic [2:0]       r_xbar_sel;
  logic [2:0]       r_ptr;
  logic [LEN_W:0]   r_wd;
  logic [LEN_W:0]   r_limit;
  logic             r_timeout_err;

  logic             w_found;
  logic [2:0]       w_win_idx;
  logic [LEN_W-1:0] w_win_len;
  logic [LEN_W:0]   w_win_limit;
  logic [2:0]       w_gfid;
  logic             w_xfer;
  logic             w_tail;
  logic [LEN_W:0]   w_wd_inc;
  logic             w_timeout;

  assign w_req    = {Sreq, Wreq, Ereq, Nreq, Lreq};
  assign w_fid[0] = Lflit_id;
  assign w_fid[1] = Nflit_id;
  assign w_fid[2] = Eflit_id;
  assign w_fid[3] = Wflit_id;
  assign w_fid[4] = Sflit_id;
  assign w_len[0] = Llength;
  assign w_len[1] = Nlength;
  assign w_len[2] = Elength;
  assign w_len[3] = Wlength;
  assign w_len[4] = Slength;

  generate
    for (genvar i = 0; i < 5; i++) begin : g_cand
      assign w_cand[i] = w_req[i] && (w_fid[i] == c_FLIT_HEAD);
    end
  endgenerate

  function automatic logic [2:0] f_wrap(input logic [2:0] p, input int k);
    logic [3:0] s;
    s = {1'b0, p} + 4'(k);
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  // Round-robin search: first header candidate at or above ptr, mod 5
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (!w_found && w_cand[f_wrap(r_ptr, k)]) begin
        w_found   = 1'b1;
        w_win_idx = f_wrap(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_win_len = '0;
    w_gfid    = 3'b000;
    for (int i = 0; i < 5; i++) begin
      if (w_win_idx == 3'(i)) w_win_len = w_len[i];
      if (r_grant[i])         w_gfid    = w_gfid | w_fid[i];
    end
  end

  // Zero length counts as one flit; limit is one bit wider so it never wraps
  assign w_win_limit = ((w_win_len == '0) ? (LEN_W+1)'(1) : {1'b0, w_win_len})
                       + (LEN_W+1)'(SLACK);

  assign w_xfer    = (|(r_grant & w_req)) && out_ready;
  assign w_tail    = w_xfer && (w_gfid == c_FLIT_TAIL);
  assign w_wd_inc  = (r_wd == '1) ? r_wd : r_wd + 1'b1;
  assign w_timeout = (w_wd_inc >= r_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_grant       <= 5'b00000;
      r_xbar_sel    <= c_NO_SEL;
      r_ptr         <= 3'd0;
      r_wd          <= '0;
      r_limit       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_grant    <= 5'(1) << w_win_idx;
            r_xbar_sel <= w_win_idx;
            r_limit    <= w_win_limit;
            r_wd       <= '0;
            r_state    <= c_HOLD;
          end
        end
        c_HOLD: begin
          r_wd <= w_wd_inc;
          // A tail arriving on the deadline cycle is a clean release
          if (w_tail || w_timeout) begin
            r_state       <= c_IDLE;
            r_grant       <= 5'b00000;
            r_xbar_sel    <= c_NO_SEL;
            r_ptr         <= f_wrap(r_xbar_sel, 1);
            r_timeout_err <= !w_tail;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign xbar_sel    = r_xbar_sel;
  assign busy        = (r_state == c_HOLD);
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_packet_rr_arbiter.sv
// ============================================================================
// Module   : tb_packet_rr_arbiter
// Purpose  : Directed scoreboard bench for packet_rr_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_packet_rr_arbiter;

  localparam int LEN_W = 12;
  localparam logic [2:0] HD = 3'b001;
  localparam logic [2:0] BD = 3'b010;
  localparam logic [2:0] TL = 3'b100;

  logic             clk;
  logic             rst;
  logic             req [5];
  logic [2:0]       fid [5];
  logic [LEN_W-1:0] len [5];
  logic             out_ready;
  logic [4:0]       grant;
  logic [2:0]       xbar_sel;
  logic             busy;
  logic             timeout_err;

  typedef struct {
    string    tag;
    logic [4:0] g;
    logic [2:0] x;
    logic     b;
    logic     t;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  packet_rr_arbiter #(.LEN_W(LEN_W), .SLACK(4)) dut (
    .clk(clk), .rst(rst),
    .Lreq(req[0]), .Nreq(req[1]), .Ereq(req[2]), .Wreq(req[3]), .Sreq(req[4]),
    .Lflit_id(fid[0]), .Nflit_id(fid[1]), .Eflit_id(fid[2]),
    .Wflit_id(fid[3]), .Sflit_id(fid[4]),
    .Llength(len[0]), .Nlength(len[1]), .Elength(len[2]),
    .Wlength(len[3]), .Slength(len[4]),
    .out_ready(out_ready),
    .grant(grant), .xbar_sel(xbar_sel), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [4:0] g, input logic [2:0] x,
                      input logic b, input logic t);
    exp_t e;
    e.tag = tag; e.g = g; e.x = x; e.b = b; e.t = t;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      assert ({grant, xbar_sel, busy, timeout_err} === {e.g, e.x, e.b, e.t})
      else begin
        bad++;
        $error("FAIL %s: observed grant=%b xbar_sel=%0d busy=%b timeout_err=%b expected grant=%b xbar_sel=%0d busy=%b timeout_err=%b",
               e.tag, grant, xbar_sel, busy, timeout_err, e.g, e.x, e.b, e.t);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic setp(input int p, input logic r, input logic [2:0] f,
                      input logic [LEN_W-1:0] l);
    req[p] = r; fid[p] = f; len[p] = l;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 5; i++) setp(i, 1'b0, 3'b000, '0);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    clear_all();
    step();
    push("reset_state", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    // Single packet on N, length 3
    setp(1, 1'b1, HD, 12'd3);
    push("t1_grant", 5'b00010, 3'd1, 1'b1, 1'b0);
    step();
    setp(1, 1'b1, BD, 12'd0);
    push("t1_body1", 5'b00010, 3'd1, 1'b1, 1'b0);
    step();
    push("t1_body2", 5'b00010, 3'd1, 1'b1, 1'b0);
    step();
    setp(1, 1'b1, TL, 12'd0);
    push("t1_release", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    clear_all();
    push("t1_idle", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();

    // Round robin L -> E -> S -> L, each packet header then tail
    sync_reset();
    setp(0, 1'b1, HD, 12'd1);
    setp(2, 1'b1, HD, 12'd1);
    setp(4, 1'b1, HD, 12'd1);
    push("rr_L", 5'b00001, 3'd0, 1'b1, 1'b0);
    step();
    setp(0, 1'b1, TL, 12'd1);
    push("rr_L_rel", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    setp(0, 1'b1, HD, 12'd1);
    push("rr_E", 5'b00100, 3'd2, 1'b1, 1'b0);
    step();
    setp(2, 1'b1, TL, 12'd1);
    push("rr_E_rel", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    setp(2, 1'b1, HD, 12'd1);
    push("rr_S", 5'b10000, 3'd4, 1'b1, 1'b0);
    step();
    setp(4, 1'b1, TL, 12'd1);
    push("rr_S_rel", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    setp(4, 1'b1, HD, 12'd1);
    push("rr_wrap_L", 5'b00001, 3'd0, 1'b1, 1'b0);
    step();
    setp(0, 1'b1, TL, 12'd1);
    push("rr_L2_rel", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    clear_all();

    // Backpressure on E, length 2: header, 3 stalled cycles, tail
    setp(2, 1'b1, HD, 12'd2);
    push("bp_grant", 5'b00100, 3'd2, 1'b1, 1'b0);
    step();
    push("bp_hdr_xfer", 5'b00100, 3'd2, 1'b1, 1'b0);
    step();
    out_ready = 1'b0;
    setp(2, 1'b1, TL, 12'd0);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("bp_stall%0d", i), 5'b00100, 3'd2, 1'b1, 1'b0);
      step();
    end
    out_ready = 1'b1;
    push("bp_release", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    clear_all();

    // Timeout on W, length 2: deadline 6 cycles after grant
    setp(3, 1'b1, HD, 12'd2);
    setp(4, 1'b1, HD, 12'd1);
    push("to_grant_W", 5'b01000, 3'd3, 1'b1, 1'b0);
    step();
    setp(3, 1'b0, 3'b000, 12'd0);
    for (int i = 1; i <= 5; i++) begin
      push($sformatf("to_hold%0d", i), 5'b01000, 3'd3, 1'b1, 1'b0);
      step();
    end
    setp(3, 1'b1, HD, 12'd2);
    push("to_pulse", 5'b00000, 3'd7, 1'b0, 1'b1);
    step();
    push("to_next_S", 5'b10000, 3'd4, 1'b1, 1'b0);
    step();
    setp(4, 1'b1, TL, 12'd0);
    push("to_S_rel", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    clear_all();

    // Tail lands exactly on the deadline cycle (N, length 2)
    setp(1, 1'b1, HD, 12'd2);
    push("co_grant", 5'b00010, 3'd1, 1'b1, 1'b0);
    step();
    setp(1, 1'b1, BD, 12'd0);
    push("co_body", 5'b00010, 3'd1, 1'b1, 1'b0);
    step();
    out_ready = 1'b0;
    setp(1, 1'b1, TL, 12'd0);
    for (int i = 2; i <= 5; i++) begin
      push($sformatf("co_stall%0d", i), 5'b00010, 3'd1, 1'b1, 1'b0);
      step();
    end
    out_ready = 1'b1;
    push("co_tail_wins", 5'b00000, 3'd7, 1'b0, 1'b0);
    step();
    clear_all();

    // Zero length acts as one: deadline 5 cycles after grant (L)
    setp(0, 1'b1, HD, 12'd0);
    push("z_grant", 5'b00001, 3'd0, 1'b1, 1'b0);
    step();
    clear_all();
    for (int i = 1; i <= 4; i++) begin
      push($sformatf("z_hold%0d", i), 5'b00001, 3'd0, 1'b1, 1'b0);
      step();
    end
    push("z_pulse", 5'b00000, 3'd7, 1'b0, 1'b1);
    step();

    // Asynchronous reset in the middle of an N packet
    setp(1, 1'b1, HD, 12'd3);
    push("ar_grant_N", 5'b00010, 3'd1, 1'b1, 1'b0);
    step();
    setp(0, 1'b1, HD, 12'd1);
    #2;
    rst = 1'b1;
    #1;
    push("ar_immediate", 5'b00000, 3'd7, 1'b0, 1'b0);
    drain();
    #1;
    rst = 1'b0;
    push("ar_L_first", 5'b00001, 3'd0, 1'b1, 1'b0);
    step();
    clear_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
